product_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of `four_bit_multiplier`. It takes the 8-bit `product` bus through a valid/ready handshake and sums a fixed batch of `COUNT` products. It then presents the batch total with its own valid/ready handshake and clears itself for the next batch. It turns the combinational multiplier into a dot-product / multiply-accumulate datapath for 4-bit operand vectors.

---
 rtl/product_accumulator_if.sv | 38 +++
 rtl/product_accumulator.sv | 91 +++++++++
 tb/tb_product_accumulator.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Bundles the two valid/ready handshakes of the product accumulator:
//   the product input stream and the batch-total output stream.
//
//   Signals:
//     in_valid   producer -> accumulator   product is valid
//     in_ready   accumulator -> producer   a product can be accepted
//     product    producer -> accumulator   8-bit unsigned product
//     out_valid  accumulator -> consumer   sum holds a completed batch
//     out_ready  consumer -> accumulator   consumer takes sum
//     sum        accumulator -> consumer   ACC_W-bit batch total
//     count      accumulator -> observer   products accepted this batch
//
//   Modports:
//     master  the environment (product source and sum sink)
//     slave   the accumulator itself
interface product_accumulator_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, product, out_ready,
    input  in_ready, out_valid, sum, count
  );

  modport slave (
    input  in_valid, product, out_ready,
    output in_ready, out_valid, sum, count
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a fixed batch of COUNT unsigned 8-bit products arriving over a
//   valid/ready handshake, then presents the batch total over a second
//   valid/ready handshake and clears itself for the next batch. Sits
//   directly downstream of four_bit_multiplier to form a multiply-
//   accumulate / dot-product datapath.
//
//   Parameters:
//     COUNT  products per batch (1..16)
//     ACC_W  accumulator / sum width, >= 8 + clog2(COUNT)
//     CNT_W  width of count, must hold 0..COUNT
//
//   Ports:
//     clk    single clock, rising edge
//     rst    synchronous active-high reset (highest priority)
//     flush  synchronous batch abort (below rst, above handshakes)
//     bus    product_accumulator_if.slave: in_valid/in_ready/product,
//            out_valid/out_ready/sum, count
module product_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  product_accumulator_if.slave  bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Unsigned add with zero-extended product; wraps modulo 2^ACC_W when
  // ACC_W is chosen too small for the batch.
  function automatic logic [ACC_W-1:0] acc_add(
    input logic [ACC_W-1:0] a,
    input logic [7:0]       p
  );
    return a + ACC_W'(p);
  endfunction

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt;

  // Handshake flags come from registered state only; rst merely masks
  // in_ready so nothing is offered while the block is held in reset.
  assign bus.in_ready  = (state == ACCUM) && !rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.sum       = sum_q;
  assign bus.count     = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      sum_q <= '0;
      cnt   <= '0;
    end else if (flush) begin
      // Abort: drops partial batch or pending result, sum left as is.
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == ACCUM) begin
      if (bus.in_valid) begin
        if (cnt == CNT_LAST) begin
          sum_q <= acc_add(acc, bus.product);
          acc   <= '0;
          cnt   <= CNT_FULL;
          state <= HOLD;
        end else begin
          acc   <= acc_add(acc, bus.product);
          cnt   <= cnt + CNT_ONE;
        end
      end
    end else begin
      if (bus.out_ready) begin
        state <= ACCUM;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush4, flush16, flush1;
  int   n_cmp = 0;
  int   n_bad = 0;

  product_accumulator_if #(.ACC_W(12), .CNT_W(5)) bus4();
  product_accumulator_if #(.ACC_W(12), .CNT_W(5)) bus16();
  product_accumulator_if #(.ACC_W(8),  .CNT_W(1)) bus1();

  product_accumulator #(.COUNT(4), .ACC_W(12), .CNT_W(5)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .bus(bus4));
  product_accumulator #(.COUNT(16), .ACC_W(12), .CNT_W(5)) dut16 (
    .clk(clk), .rst(rst), .flush(flush16), .bus(bus16));
  product_accumulator #(.COUNT(1), .ACC_W(8), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(bus1));

  // Advance one clock; inputs changed after this take effect next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put4(input logic [7:0] p);
    bus4.in_valid = 1'b1;
    bus4.product  = p;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus4.in_valid  = 1'($urandom);
      bus4.product   = 8'($urandom);
      bus4.out_ready = 1'($urandom);
      flush4         = 1'($urandom);
      bus16.in_valid = 1'($urandom);
      bus16.product  = 8'($urandom);
      cyc();
      n_cmp++;
      if ({bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum} !== {1'b0, 1'b0, 5'd0, 12'd0}) begin
        n_bad++;
        $display("FAIL reset_during: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=0 ir=0 cnt=0 sum=0",
                 bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum);
      end
    end
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; flush4 = 1'b0;
    bus16.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum} !== {1'b0, 1'b1, 5'd0, 12'd0}) begin
      n_bad++;
      $display("FAIL reset_release: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=0 ir=1 cnt=0 sum=0",
               bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum);
    end
    n_cmp++;
    if ({bus16.out_valid, bus16.in_ready, bus16.count, bus16.sum} !== {1'b0, 1'b1, 5'd0, 12'd0}) begin
      n_bad++;
      $display("FAIL reset_release16: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=0 ir=1 cnt=0 sum=0",
               bus16.out_valid, bus16.in_ready, bus16.count, bus16.sum);
    end
    cyc();
  endtask

  task automatic test_basic();
    logic [7:0] vals [4] = '{8'd35, 8'd24, 8'd0, 8'd225};
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put4(vals[i]);
      n_cmp++;
      if ({bus4.out_valid, bus4.in_ready, bus4.count} !== {1'b0, 1'b1, 5'(i + 1)}) begin
        n_bad++;
        $display("FAIL basic_accept%0d: ov=%0b ir=%0b cnt=%0d want ov=0 ir=1 cnt=%0d",
                 i, bus4.out_valid, bus4.in_ready, bus4.count, i + 1);
      end
    end
    put4(vals[3]);
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum} !== {1'b1, 1'b0, 5'd4, 12'd284}) begin
      n_bad++;
      $display("FAIL basic_hold: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=1 ir=0 cnt=4 sum=284",
               bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum);
    end
    cyc();
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum} !== {1'b0, 1'b1, 5'd0, 12'd284}) begin
      n_bad++;
      $display("FAIL basic_after: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=0 ir=1 cnt=0 sum=284",
               bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum);
    end
  endtask

  task automatic test_backpressure();
    bus4.out_ready = 1'b0;
    put4(8'd35);
    bus4.in_valid = 1'b0;
    cyc(); cyc();
    n_cmp++;
    if (bus4.count !== 5'd1) begin
      n_bad++;
      $display("FAIL gap_count: cnt=%0d want 1", bus4.count);
    end
    put4(8'd24);
    bus4.in_valid = 1'b0;
    cyc(); cyc();
    put4(8'd1);
    put4(8'd1);
    // Offer a product that must be ignored while the result is held.
    bus4.in_valid = 1'b1;
    bus4.product  = 8'd200;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum} !== {1'b1, 1'b0, 5'd4, 12'd61}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=1 ir=0 cnt=4 sum=61",
                 i, bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum);
      end
      cyc();
    end
    n_cmp++;
    if ({bus4.out_valid, bus4.sum} !== {1'b1, 12'd61}) begin
      n_bad++;
      $display("FAIL bp_still_hold: ov=%0b sum=%0d want ov=1 sum=61", bus4.out_valid, bus4.sum);
    end
    bus4.out_ready = 1'b1;
    cyc();
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count} !== {1'b0, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL bp_transfer: ov=%0b ir=%0b cnt=%0d want ov=0 ir=1 cnt=0",
               bus4.out_valid, bus4.in_ready, bus4.count);
    end
  endtask

  task automatic test_max();
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    bus16.product   = 8'd225;
    for (int i = 0; i < 15; i++) cyc();
    n_cmp++;
    if ({bus16.out_valid, bus16.count} !== {1'b0, 5'd15}) begin
      n_bad++;
      $display("FAIL max_15: ov=%0b cnt=%0d want ov=0 cnt=15", bus16.out_valid, bus16.count);
    end
    cyc();
    bus16.in_valid = 1'b0;
    n_cmp++;
    if ({bus16.out_valid, bus16.count, bus16.sum} !== {1'b1, 5'd16, 12'd3600}) begin
      n_bad++;
      $display("FAIL max_sum: ov=%0b cnt=%0d sum=%0d want ov=1 cnt=16 sum=3600",
               bus16.out_valid, bus16.count, bus16.sum);
    end
    cyc();
    n_cmp++;
    if ({bus16.out_valid, bus16.in_ready, bus16.count} !== {1'b0, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL max_after: ov=%0b ir=%0b cnt=%0d want ov=0 ir=1 cnt=0",
               bus16.out_valid, bus16.in_ready, bus16.count);
    end
  endtask

  task automatic test_flush();
    bus4.out_ready = 1'b1;
    put4(8'd10);
    put4(8'd20);
    flush4 = 1'b1;
    put4(8'd99);
    flush4 = 1'b0;
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count} !== {1'b0, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL flush_count: ov=%0b ir=%0b cnt=%0d want ov=0 ir=1 cnt=0",
               bus4.out_valid, bus4.in_ready, bus4.count);
    end
    put4(8'd1); put4(8'd2); put4(8'd3); put4(8'd4);
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.sum} !== {1'b1, 12'd10}) begin
      n_bad++;
      $display("FAIL flush_next: ov=%0b sum=%0d want ov=1 sum=10", bus4.out_valid, bus4.sum);
    end
    cyc();
  endtask

  task automatic test_hold_abort();
    // rst while holding a result
    bus4.out_ready = 1'b0;
    put4(8'd35); put4(8'd24); put4(8'd0); put4(8'd225);
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.sum} !== {1'b1, 12'd284}) begin
      n_bad++;
      $display("FAIL rst_hold_pre: ov=%0b sum=%0d want ov=1 sum=284", bus4.out_valid, bus4.sum);
    end
    rst = 1'b1;
    bus4.out_ready = 1'b1;
    cyc();
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum} !== {1'b0, 1'b0, 5'd0, 12'd0}) begin
      n_bad++;
      $display("FAIL rst_hold: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=0 ir=0 cnt=0 sum=0",
               bus4.out_valid, bus4.in_ready, bus4.count, bus4.sum);
    end
    rst = 1'b0;
    put4(8'd1); put4(8'd1); put4(8'd1); put4(8'd1);
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.sum} !== {1'b1, 12'd4}) begin
      n_bad++;
      $display("FAIL rst_next: ov=%0b sum=%0d want ov=1 sum=4", bus4.out_valid, bus4.sum);
    end
    cyc();
    // flush while holding a result, with out_ready high
    bus4.out_ready = 1'b0;
    put4(8'd35); put4(8'd24); put4(8'd0); put4(8'd225);
    bus4.in_valid = 1'b0;
    flush4 = 1'b1;
    bus4.out_ready = 1'b1;
    cyc();
    flush4 = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count} !== {1'b0, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL flush_hold: ov=%0b ir=%0b cnt=%0d want ov=0 ir=1 cnt=0",
               bus4.out_valid, bus4.in_ready, bus4.count);
    end
    put4(8'd2); put4(8'd2); put4(8'd2); put4(8'd2);
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.sum} !== {1'b1, 12'd8}) begin
      n_bad++;
      $display("FAIL flush_hold_next: ov=%0b sum=%0d want ov=1 sum=8", bus4.out_valid, bus4.sum);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    bus4.out_ready = 1'b1;
    put4(8'd1); put4(8'd2); put4(8'd3); put4(8'd4);
    n_cmp++;
    if ({bus4.out_valid, bus4.sum} !== {1'b1, 12'd10}) begin
      n_bad++;
      $display("FAIL b2b_first: ov=%0b sum=%0d want ov=1 sum=10", bus4.out_valid, bus4.sum);
    end
    put4(8'd100);
    n_cmp++;
    if ({bus4.out_valid, bus4.in_ready, bus4.count} !== {1'b0, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL b2b_gap: ov=%0b ir=%0b cnt=%0d want ov=0 ir=1 cnt=0",
               bus4.out_valid, bus4.in_ready, bus4.count);
    end
    put4(8'd5); put4(8'd6); put4(8'd7); put4(8'd8);
    bus4.in_valid = 1'b0;
    n_cmp++;
    if ({bus4.out_valid, bus4.sum} !== {1'b1, 12'd26}) begin
      n_bad++;
      $display("FAIL b2b_second: ov=%0b sum=%0d want ov=1 sum=26", bus4.out_valid, bus4.sum);
    end
    cyc();
  endtask

  task automatic test_count_one();
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.product   = 8'd200;
    cyc();
    bus1.in_valid = 1'b0;
    n_cmp++;
    if ({bus1.out_valid, bus1.in_ready, bus1.count, bus1.sum} !== {1'b1, 1'b0, 1'b1, 8'd200}) begin
      n_bad++;
      $display("FAIL one_hold: ov=%0b ir=%0b cnt=%0d sum=%0d want ov=1 ir=0 cnt=1 sum=200",
               bus1.out_valid, bus1.in_ready, bus1.count, bus1.sum);
    end
    bus1.out_ready = 1'b1;
    cyc();
    bus1.in_valid = 1'b1;
    bus1.product  = 8'd7;
    cyc();
    bus1.in_valid = 1'b0;
    n_cmp++;
    if ({bus1.out_valid, bus1.sum} !== {1'b1, 8'd7}) begin
      n_bad++;
      $display("FAIL one_next: ov=%0b sum=%0d want ov=1 sum=7", bus1.out_valid, bus1.sum);
    end
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    flush4 = 1'b0; flush16 = 1'b0; flush1 = 1'b0;
    bus4.in_valid = 1'b0;  bus4.product = 8'd0;  bus4.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.product = 8'd0; bus16.out_ready = 1'b0;
    bus1.in_valid = 1'b0;  bus1.product = 8'd0;  bus1.out_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_max();
    test_flush();
    test_hold_abort();
    test_back_to_back();
    test_count_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
